opb_register_simulink2ppc_stat: RTL
===================================

// Module: opb_register_simulink2ppc_stat
// PURPOSE
//   OPB slave that lets the PowerPC read a 32-bit value produced by fabric logic.
//   This is the fabric-to-PPC counterpart of the PPC-to-fabric software register.
//   Fabric strobes user_valid to capture a word; the PPC reads that word plus a status word.
//   Status holds a fresh flag and a saturating overrun count.
//   Sits on the shared OPB next to the ppc2simulink registers, in the same address window style.
// PARAMETERS
//   C_BASEADDR    32'h01003700  first byte address of the 256-byte window
//   C_HIGHADDR    32'h010037FF  last byte address of the window
//   C_OPB_AWIDTH  32            OPB address width
//   C_OPB_DWIDTH  32            OPB data width
//   C_FAMILY      "virtex5"     target family; informational only
// PORTS
//   OPB_Clk        in   1   single clock for both the bus and the user side
//   OPB_Rst        in   1   reset, asynchronous, active-high
//   OPB_ABus       in   32  [0:31] byte address
//   OPB_BE         in   4   [0:3] byte enables
//   OPB_DBus       in   32  [0:31] write data
//   OPB_RNW        in   1   1 = read, 0 = write
//   OPB_select     in   1   transfer in progress
//   OPB_seqAddr    in   1   ignored
//   Sl_DBus        out  32  [0:31] read data; all zero except in the ack cycle (wired-OR bus)
//   Sl_xferAck     out  1   one-cycle transfer acknowledge
//   Sl_errAck      out  1   tied 0
//   Sl_retry       out  1   tied 0
//   Sl_toutSup     out  1   tied 0
//   user_data_in   in   32  [31:0] word to capture
//   user_valid     in   1   capture strobe, one word per cycle it is high
// BEHAVIOUR
//   - One clock only: OPB_Clk. Reset OPB_Rst is asynchronous and active-high.
//   - Reset state: all registers 0; FSM in IDLE; Sl_DBus = 0; Sl_xferAck = 0.
//   - Hit condition: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
//   - Offset is OPB_ABus[24:29] (word index) relative to the base.
//   - Register map:
//     - 0x0  DATA.
//     - 0x4  STATUS: bit31 = fresh, bits[15:0] = overrun count, other bits 0.
//     - 0x8  TIMESTAMP (see CONFIGURATION).
//     - Any other offset reads 0.
//   - FSM states:
//     - IDLE -> ACK on a hit.
//     - ACK: Sl_xferAck=1 for exactly one cycle; always moves to WAIT.
//     - WAIT -> IDLE once OPB_select=0. This guarantees exactly one ack per select.
//   - Latency: hit sampled at clock edge N; Sl_xferAck and Sl_DBus are valid in cycle N+1.
//   - Sl_DBus is registered: loaded on the IDLE->ACK edge, cleared on the next edge.
//   - Bit order: Sl_DBus[0] = DATA[31], i.e. MSB-first mapping to the big-endian bus.
//   - Byte enables are ignored on reads.
//   - Writes are acknowledged identically to reads.
//     - A write to 0x4 with any OPB_BE bit set clears the overrun count.
//     - All other writes are acknowledged and ignored.
//   - Capture: user_valid=1 at an edge -> DATA <= user_data_in and fresh <= 1 at that edge.
//     - If fresh was already 1 and is not being cleared that cycle, overrun increments.
//     - Overrun saturates at 16'hFFFF.
//   - Fresh clear: fresh <= 0 on the IDLE->ACK edge of a read at offset 0x0.
//   - Simultaneous capture and DATA read on the same edge:
//     - The read returns the old DATA.
//     - fresh stays 1 (capture wins).
//     - Overrun does not increment.
//   - Simultaneous capture and a write clearing overrun: the clear wins; the count becomes 0.
//   - Reset asserted mid-transfer: the ack is aborted and the FSM returns to IDLE.
//     The bus master's timeout handles the aborted transfer.
// CONFIGURATION
//   - Macro: SIMULINK2PPC_TIMESTAMP_EN.
//   - Defined:
//     - A 32-bit free-running cycle counter is instantiated; it wraps 0xFFFFFFFF -> 0 and resets to 0.
//     - On each capture the counter value is latched into TIMESTAMP at offset 0x8.
//   - Undefined: no counter is built, and offset 0x8 reads 0.
// TESTING
//   - Reset: after reset, read 0x0 and 0x4 -> both return 0; ack lands 1 cycle after the hit.
//   - Capture/read:
//     - Pulse user_valid with data 0xDEADBEEF.
//     - Read 0x4 -> 0x80000000.
//     - Read 0x0 -> 0xDEADBEEF.
//     - Read 0x4 again -> 0x00000000.
//   - Overrun: five captures with no read -> STATUS = 0x80000004.
//     Then write 0x4 -> STATUS = 0x80000000.
//   - Collision: capture 0x11111111 and read 0x0 on the same edge.
//     - The read returns the prior DATA.
//     - The next STATUS read shows fresh = 1 and overrun unchanged.
//   - Bus hygiene:
//     - Hold OPB_select for 6 cycles -> exactly one Sl_xferAck.
//     - Sl_DBus = 0 in every non-ack cycle.
//     - An address outside the window gets no ack.
//   - With SIMULINK2PPC_TIMESTAMP_EN: a capture 100 cycles after reset -> TIMESTAMP = 100 +/- 1 (fixed by design).
//     Without the macro: TIMESTAMP reads 0.

Source files
------------

// File: rtl/opb_register_simulink2ppc_stat.sv
// OPB slave exposing a fabric-captured 32-bit word plus a fresh/overrun status word to the PPC.
// Optional build macro SIMULINK2PPC_TIMESTAMP_EN adds a free-running cycle counter latched on capture.
module opb_register_simulink2ppc_stat #(
    parameter logic [31:0] C_BASEADDR   = 32'h01003700,
    parameter logic [31:0] C_HIGHADDR   = 32'h010037FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_valid,
    output logic [1:0]                  dbg_state_o
);

    // Handshake: a transfer is presented by holding OPB_select with a stable address; the slave
    // answers with exactly one Sl_xferAck pulse and then waits for OPB_select to drop.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] data_q;
    logic        fresh_q, fresh_d;
    logic [15:0] ovr_q, ovr_d;
    logic [31:0] ts_word;

    logic        hit;
    logic        start;
    logic [5:0]  word_off;
    logic        data_read;
    logic        ovr_clear;
    logic [31:0] status_word;

    logic unused_inputs;
    assign unused_inputs = ^{OPB_DBus, OPB_seqAddr, (C_FAMILY == "virtex5")};

    assign hit       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign start     = (state_q == IDLE) && hit;
    assign word_off  = OPB_ABus[24:29];
    assign data_read = start && OPB_RNW && (word_off == 6'd0);
    assign ovr_clear = start && !OPB_RNW && (word_off == 6'd1) && (|OPB_BE);

    assign status_word = {fresh_q, 15'd0, ovr_q};

`ifdef SIMULINK2PPC_TIMESTAMP_EN
    logic [31:0] cnt_q;
    logic [31:0] ts_q;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            cnt_q <= '0;
            ts_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (user_valid) begin
                ts_q <= cnt_q;
            end
        end
    end

    assign ts_word = ts_q;
`else
    assign ts_word = '0;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ACK;
                    if (OPB_RNW) begin
                        case (word_off)
                            6'd0:    rdata_d = data_q;
                            6'd1:    rdata_d = status_word;
                            6'd2:    rdata_d = ts_word;
                            default: rdata_d = '0;
                        endcase
                    end
                end
            end
            ACK:     state_d = WAIT;
            WAIT:    if (!OPB_select) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A capture on the same edge as a DATA read keeps fresh set; the clear only applies otherwise.
    always_comb begin
        fresh_d = fresh_q;
        ovr_d   = ovr_q;
        if (user_valid) begin
            fresh_d = 1'b1;
        end else if (data_read) begin
            fresh_d = 1'b0;
        end
        if (ovr_clear) begin
            ovr_d = '0;
        end else if (user_valid && fresh_q && !data_read && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            data_q  <= '0;
            fresh_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            fresh_q <= fresh_d;
            ovr_q   <= ovr_d;
            if (user_valid) begin
                data_q <= user_data_in;
            end
        end
    end

    // Vector assignment maps rdata_q[31] onto bus bit 0 (big-endian MSB-first).
    assign Sl_DBus     = rdata_q;
    assign Sl_xferAck  = (state_q == ACK);
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign dbg_state_o = state_q;

endmodule
